add16_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that runs wide add/subtract operations on a single 16-bit fast-adder slice.
- Processes one 16-bit word per cycle, LSW first, and chains the carry through a register.
- Takes operands through a valid/ready handshake and returns the full-width result plus flags through a second valid/ready handshake.
- Sits between the integer execute stage and the shared 16-bit adder, so wide arithmetic needs no wide carry-lookahead logic.

---
 rtl/add16_seq_ctrl_pkg.sv | 22 ++
 rtl/add16_seq_ctrl_slice.sv | 51 +++++
 rtl/add16_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_add16_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/add16_seq_ctrl_pkg.sv
// Shared types and constants for the add16_seq_ctrl wide add/subtract sequencer.
// Saturation helpers are used only when ADD16_SEQ_SAT_EN is defined.
package add16_seq_ctrl_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } CtrlState;

    // Most significant word of the saturated result: largest positive or most negative value
    function automatic logic [SLICE_W-1:0] satTopWord(input logic aMsb);
        return aMsb ? 16'h8000 : 16'h7FFF;
    endfunction

    function automatic logic [SLICE_W-1:0] satLowWord(input logic aMsb);
        return aMsb ? 16'h0000 : 16'hFFFF;
    endfunction

endpackage

// File: rtl/add16_seq_ctrl_slice.sv
// add16_slice: purely combinational 16-bit adder built from four 4-bit
// carry-lookahead groups, so the shared slice needs no long ripple chain.
module add16_slice
    import add16_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_c;
    logic [3:0]         w_grpP;
    logic [3:0]         w_grpG;
    logic [4:0]         w_grpC;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Group propagate/generate first, then carries between groups, then carries inside each group
    always_comb begin
        w_grpP = '0;
        w_grpG = '0;
        w_grpC = '0;
        w_c    = '0;
        for (int k = 0; k < 4; k++) begin
            w_grpP[k] = &w_p[4*k +: 4];
            w_grpG[k] = w_g[4*k+3]
                      | (w_p[4*k+3] & w_g[4*k+2])
                      | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                      | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        end
        w_grpC[0] = i_cin;
        for (int k = 0; k < 4; k++) begin
            w_grpC[k+1] = w_grpG[k] | (w_grpP[k] & w_grpC[k]);
        end
        for (int k = 0; k < 4; k++) begin
            w_c[4*k] = w_grpC[k];
            for (int j = 1; j < 4; j++) begin
                w_c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & w_c[4*k+j-1]);
            end
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_grpC[4];

endmodule

// File: rtl/add16_seq_ctrl.sv
// Multi-cycle wide add/subtract sequencer over one shared 16-bit adder slice, LSW first.
// Optional: define ADD16_SEQ_SAT_EN to saturate the result on signed overflow.
module add16_seq_ctrl
    import add16_seq_ctrl_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int WIDTH = SLICE_W * WORDS
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    CtrlState           r_state;
    CtrlState           w_nextState;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_res;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_zeroAcc;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;

    logic [SLICE_W-1:0] w_aWord;
    logic [SLICE_W-1:0] w_bWord;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_lastWord;
    logic               w_finalOvf;
    logic               w_finalZero;

    assign w_aWord = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_bWord = r_b[r_idx*SLICE_W +: SLICE_W];

    add16_slice u_slice (
        .i_a    (w_aWord),
        .i_b    (w_bWord),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_lastWord  = (r_state == RUN) && (r_idx == LAST_IDX);
    assign w_finalOvf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[SLICE_W-1] != r_a[WIDTH-1]);
    assign w_finalZero = r_zeroAcc && (w_sum == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // No overlap between operations: a new request is taken only once the result has been consumed
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Partial words collect in r_work; r_res only changes at the RUN->DONE edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_work    <= '0;
            r_res     <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_zeroAcc <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_accept) begin
            r_a       <= in_a;
            r_b       <= in_sub ? ~in_b : in_b;
            r_carry   <= in_sub;
            r_idx     <= '0;
            r_zeroAcc <= 1'b1;
        end else if (r_state == RUN) begin
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_sum != '0) begin
                r_zeroAcc <= 1'b0;
            end
            for (int w = 0; w < WORDS; w++) begin
                if (r_idx == IDX_W'(w)) begin
                    r_work[w*SLICE_W +: SLICE_W] <= w_sum;
                end
            end
            if (w_lastWord) begin
                for (int w = 0; w < WORDS; w++) begin
                    r_res[w*SLICE_W +: SLICE_W] <= (r_idx == IDX_W'(w)) ? w_sum
                                                   : r_work[w*SLICE_W +: SLICE_W];
                end
                r_cout <= w_cout;
                r_ovf  <= w_finalOvf;
                r_zero <= w_finalZero;
`ifdef ADD16_SEQ_SAT_EN
                if (w_finalOvf) begin
                    for (int w = 0; w < WORDS; w++) begin
                        r_res[w*SLICE_W +: SLICE_W] <= (w == WORDS - 1) ? satTopWord(r_a[WIDTH-1])
                                                       : satLowWord(r_a[WIDTH-1]);
                    end
                    r_zero <= 1'b0;
                end
`endif
            end
        end
    end

    assign out_res  = r_res;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;
    assign out_zero = r_zero;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Directed self-checking bench for add16_seq_ctrl (WORDS=4) with hand-computed results.
// Overflow expectations follow ADD16_SEQ_SAT_EN when it is defined.
module tb_add16_seq_ctrl;

    localparam int WORDS = 4;
    localparam int WIDTH = 16 * WORDS;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             busy;

    int checkCount = 0;
    int errorCount = 0;

    add16_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request and return #1 after the edge that accepts it
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("in_ready before request", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) begin
            checkOutput("result timeout", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic checkResult(input string tag, input logic [63:0] expRes,
                               input logic expCout, input logic expOvf, input logic expZero);
        checkOutput({tag, " res"},  out_res,          expRes);
        checkOutput({tag, " cout"}, 64'(out_cout),    64'(expCout));
        checkOutput({tag, " ovf"},  64'(out_ovf),     64'(expOvf));
        checkOutput({tag, " zero"}, 64'(out_zero),    64'(expZero));
    endtask

    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after ready"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " in_ready after ready"},  64'(in_ready),  64'd1);
    endtask

    task automatic runOp(input string tag, input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic [63:0] expRes, input logic expCout, input logic expOvf,
                         input logic expZero);
        int cycles;
        applyStimulus(a, b, sub);
        checkOutput({tag, " busy in RUN"}, 64'(busy), 64'd1);
        waitResult(cycles);
        checkOutput({tag, " latency"}, 64'(cycles), 64'd4);
        checkResult(tag, expRes, expCout, expOvf, expZero);
        releaseResult(tag);
    endtask

    initial begin
        logic [63:0] heldRes;
        int          cycles;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy",      64'(busy),      64'd0);
        checkResult("reset", 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        runOp("carry ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        runOp("sub to zero", 64'h5, 64'h5, 1'b1,
              64'h0, 1'b1, 1'b0, 1'b1);
        runOp("unsigned wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h0, 1'b1, 1'b0, 1'b1);
`ifdef ADD16_SEQ_SAT_EN
        runOp("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        runOp("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
`endif
        runOp("borrow", 64'h3, 64'h5, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: result must hold while a competing request is refused
        applyStimulus(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0);
        waitResult(cycles);
        checkResult("backpressure", 64'h0011_0022_0033_0044, 1'b0, 1'b0, 1'b0);
        heldRes  = out_res;
        in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b     = 64'h1;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("held out_valid", 64'(out_valid), 64'd1);
            checkOutput("held in_ready",  64'(in_ready),  64'd0);
            checkOutput("held out_res",   out_res,        heldRes);
            checkOutput("held zero",      64'(out_zero),  64'd0);
        end
        in_valid = 1'b0;
        releaseResult("backpressure");
        @(posedge clk); #1;
        checkOutput("ignored request busy", 64'(busy), 64'd0);
        checkOutput("result kept in IDLE", out_res, 64'h0011_0022_0033_0044);
        runOp("after backpressure", 64'h1, 64'h2, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Reset in the second RUN cycle discards the operation immediately
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("mid reset busy",      64'(busy),      64'd0);
        checkResult("mid reset", 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        runOp("after reset", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
              64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
